uart_rx_fifo: RTL and testbench

//  Parametrised UART receiver for the RISC-V UART subsystem: 16x oversampled RX,
//  5..9 data bits, runtime baud/parity/stop select, per-frame error tagging.

---
 rtl/uart_rx_fifo_if.sv | 11 +
 rtl/uart_rx_fifo.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Drain port of the UART RX FIFO: first-word fall-through head plus valid/ready pop.
interface uart_rx_fifo_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_perr;
  logic                 rx_ferr;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (output rx_data, rx_perr, rx_ferr, rx_valid, input rx_ready);
  modport slave  (input rx_data, rx_perr, rx_ferr, rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// 16x oversampled UART receiver with runtime baud/parity/stop select, per-frame
// error tags and a registered first-word fall-through RX FIFO.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD0      = 9600,
  parameter int BAUD1      = 19200,
  parameter int BAUD2      = 57600,
  parameter int BAUD3      = 115200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          data_rx,
  input  logic [1:0]                    baud_rate,
  input  logic [1:0]                    parity_type,
  input  logic                          stop_two,
  uart_rx_fifo_if.master                rx,
  output logic                          overrun,
  output logic                          brk,
  input  logic                          err_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = 16;
  localparam int DIV0 = CLK_FREQ / (16 * BAUD0);
  localparam int DIV1 = CLK_FREQ / (16 * BAUD1);
  localparam int DIV2 = CLK_FREQ / (16 * BAUD2);
  localparam int DIV3 = CLK_FREQ / (16 * BAUD3);

  typedef struct packed {
    logic                 ferr;
    logic                 perr;
    logic [DATA_BITS-1:0] data;
  } word_t;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [1:0] sync;
  logic       rxs;
  assign rxs = sync[1];

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync <= 2'b11;
    else          sync <= {sync[0], data_rx};

  state_t               state;
  logic [TW-1:0]        tcnt, div_m1;
  logic [3:0]           scnt, bit_cnt;
  logic [1:0]           smp;
  logic [DATA_BITS-1:0] shreg;
  logic [1:0]           baud_q, par_q;
  logic                 two_q, second, zeros, ferr_q, perr_q, wait_high;
  logic                 push, brk_evt;
  word_t                push_word;
  logic                 tick, mid, maj, par_en, odd_sel, stop_ferr;

  always_comb begin
    unique case (baud_q)
      2'b00:   div_m1 = TW'(DIV0 - 1);
      2'b01:   div_m1 = TW'(DIV1 - 1);
      2'b10:   div_m1 = TW'(DIV2 - 1);
      default: div_m1 = TW'(DIV3 - 1);
    endcase
  end

  assign tick      = (state != IDLE) && (tcnt == div_m1);
  assign mid       = tick && (scnt == 4'd9);
  // third vote is the live sample taken at tick 9
  assign maj       = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);
  assign par_en    = (par_q == 2'b01) || (par_q == 2'b10);
  assign odd_sel   = (par_q == 2'b01);
  assign stop_ferr = ferr_q | ~maj;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE; tcnt <= '0; scnt <= '0; bit_cnt <= '0; smp <= '0;
      shreg <= '0; baud_q <= '0; par_q <= '0; two_q <= 1'b0; second <= 1'b0;
      zeros <= 1'b0; ferr_q <= 1'b0; perr_q <= 1'b0; wait_high <= 1'b0;
      push <= 1'b0; brk_evt <= 1'b0; push_word <= '0;
    end else begin
      push    <= 1'b0;
      brk_evt <= 1'b0;
      if (state != IDLE) begin
        tcnt <= tick ? '0 : tcnt + TW'(1);
        if (tick)                 scnt   <= scnt + 4'd1;
        if (tick && scnt == 4'd7) smp[0] <= rxs;
        if (tick && scnt == 4'd8) smp[1] <= rxs;
      end
      unique case (state)
        IDLE: begin
          if (rxs) wait_high <= 1'b0;
          else if (!wait_high) begin
            state  <= START;
            tcnt   <= '0;       scnt    <= '0;      bit_cnt <= '0;
            baud_q <= baud_rate; par_q  <= parity_type; two_q <= stop_two;
            second <= 1'b0;     zeros   <= 1'b1;
            ferr_q <= 1'b0;     perr_q  <= 1'b0;
          end
        end
        START: if (mid) state <= maj ? IDLE : DATA;
        DATA: if (mid) begin
          shreg   <= {maj, shreg[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + 4'd1;
          if (maj) zeros <= 1'b0;
          if (bit_cnt == 4'(DATA_BITS - 1)) state <= par_en ? PARITY : STOP;
        end
        PARITY: if (mid) begin
          perr_q <= ((^shreg) ^ maj) != odd_sel;
          if (maj) zeros <= 1'b0;
          state <= STOP;
        end
        STOP: if (mid) begin
          if (!second && !maj && zeros) brk_evt <= 1'b1;
          if (two_q && !second) begin
            second <= 1'b1;
            ferr_q <= stop_ferr;
          end else begin
            push      <= 1'b1;
            push_word <= '{ferr: stop_ferr, perr: perr_q, data: shreg};
            wait_high <= stop_ferr;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  word_t         mem [FIFO_DEPTH];
  word_t         head, head_n;
  logic [AW-1:0] wr_ptr, rd_ptr, rd_n;
  logic [LW-1:0] lvl_n;
  logic          do_rd, do_wr, full, ovf;

  assign do_rd  = rx.rx_valid & rx.rx_ready;
  assign full   = (fifo_level == LW'(FIFO_DEPTH));
  assign do_wr  = push & (~full | do_rd);
  assign ovf    = push & full & ~do_rd;
  assign rd_n   = rd_ptr + AW'(do_rd);
  assign lvl_n  = fifo_level + LW'(do_wr) - LW'(do_rd);
  // a word written into an empty (or just-emptied) FIFO bypasses the array
  assign head_n = (do_wr && wr_ptr == rd_n) ? push_word : mem[rd_n];

  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr] <= push_word;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0; rd_ptr <= '0; fifo_level <= '0;
      head <= '0; rx.rx_valid <= 1'b0; overrun <= 1'b0; brk <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr      <= rd_n;
      fifo_level  <= lvl_n;
      rx.rx_valid <= (lvl_n != '0);
      if (lvl_n != '0) head <= head_n;
      if (ovf)          overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
      if (brk_evt)      brk <= 1'b1;
      else if (err_clr) brk <= 1'b0;
    end
  end

  assign rx.rx_data = head.data;
  assign rx.rx_perr = head.perr;
  assign rx.rx_ferr = head.ferr;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 50 MHz; baud 11 gives 432 clk per bit, baud 01
// is overridden to 781250 (64 clk per bit) to keep the FIFO-fill run short.
module tb_uart_rx_fifo;
  localparam int DB = 8;
  localparam int D  = 16;
  localparam int B3 = 432;
  localparam int B1 = 64;

  logic       clk = 1'b0, reset_n = 1'b0, data_rx = 1'b1, stop_two = 1'b0, err_clr = 1'b0;
  logic [1:0] baud_rate = 2'b11, parity_type = 2'b00;
  logic       overrun, brk;
  logic [4:0] fifo_level;
  int         n_cmp = 0, n_err = 0;

  uart_rx_fifo_if #(.DATA_BITS(DB)) rx ();

  uart_rx_fifo #(.BAUD1(781250), .DATA_BITS(DB), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .data_rx(data_rx), .baud_rate(baud_rate),
    .parity_type(parity_type), .stop_two(stop_two), .rx(rx.master),
    .overrun(overrun), .brk(brk), .err_clr(err_clr), .fifo_level(fifo_level)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    data_rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [8:0] d, input int bclk, input logic [1:0] pt,
                            input logic flip, input logic two);
    logic [DB-1:0] dd;
    logic          pb;
    dd = d[DB-1:0];
    pb = ((pt == 2'b01) ? ~^dd : ^dd) ^ flip;
    hold(1'b0, bclk);
    for (int i = 0; i < DB; i++) hold(dd[i], bclk);
    if (pt == 2'b01 || pt == 2'b10) hold(pb, bclk);
    hold(1'b1, bclk);
    if (two) hold(1'b1, bclk);
  endtask

  task automatic pop();
    rx.rx_ready = 1'b1;
    @(negedge clk);
    rx.rx_ready = 1'b0;
  endtask

  task automatic clr_pulse();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rx.rx_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_valid", rx.rx_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_data",  rx.rx_data, 0);
    chk("rst_ovr",   overrun, 0);
    chk("rst_brk",   brk, 0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);

    // 1: clean frame, even parity
    parity_type = 2'b10;
    send_frame(9'h0A5, B3, 2'b10, 1'b0, 1'b0);
    chk("t1_valid", rx.rx_valid, 1);
    chk("t1_data",  rx.rx_data, 8'hA5);
    chk("t1_perr",  rx.rx_perr, 0);
    chk("t1_ferr",  rx.rx_ferr, 0);
    chk("t1_level", fifo_level, 1);
    pop();
    chk("t1_empty", rx.rx_valid, 0);
    chk("t1_level0", fifo_level, 0);

    // 2: odd parity, bad parity bit then a clean frame
    parity_type = 2'b01;
    send_frame(9'h007, B3, 2'b01, 1'b1, 1'b0);
    send_frame(9'h03C, B3, 2'b01, 1'b0, 1'b0);
    chk("t2_level", fifo_level, 2);
    chk("t2_data0", rx.rx_data, 8'h07);
    chk("t2_perr0", rx.rx_perr, 1);
    pop();
    chk("t2_data1", rx.rx_data, 8'h3C);
    chk("t2_perr1", rx.rx_perr, 0);
    pop();
    chk("t2_level0", fifo_level, 0);

    // 3: overrun with 17 frames into a 16-deep FIFO
    baud_rate = 2'b01; parity_type = 2'b00;
    for (int i = 0; i <= 16; i++) send_frame(9'(i), B1, 2'b00, 1'b0, 1'b0);
    chk("t3_level", fifo_level, 16);
    chk("t3_ovr",   overrun, 1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t3_drain%0d", i), rx.rx_data, i);
      pop();
    end
    chk("t3_level0", fifo_level, 0);
    chk("t3_ovr_hold", overrun, 1);
    clr_pulse();
    chk("t3_ovr_clr", overrun, 0);

    // 4: short glitch is a false start
    baud_rate = 2'b11;
    hold(1'b0, 200);
    hold(1'b1, 600);
    chk("t4_noval", rx.rx_valid, 0);
    chk("t4_level", fifo_level, 0);
    send_frame(9'h055, B3, 2'b00, 1'b0, 1'b0);
    chk("t4_data",  rx.rx_data, 8'h55);
    chk("t4_level1", fifo_level, 1);
    chk("t4_ferr",  rx.rx_ferr, 0);
    pop();

    // 5: break, line low for two frame times
    hold(1'b0, 20 * B3);
    chk("t5_brk",   brk, 1);
    chk("t5_level", fifo_level, 1);
    chk("t5_data",  rx.rx_data, 8'h00);
    chk("t5_ferr",  rx.rx_ferr, 1);
    hold(1'b1, 1000);
    chk("t5_single", fifo_level, 1);
    pop();
    clr_pulse();
    chk("t5_brk_clr", brk, 0);

    // 6: reset mid-frame, then baud/parity change during a frame
    hold(1'b0, B3);
    hold(1'b1, 3 * B3);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    hold(1'b1, 1000);
    chk("t6_level0", fifo_level, 0);
    chk("t6_valid0", rx.rx_valid, 0);
    parity_type = 2'b10;
    fork
      send_frame(9'h081, B3, 2'b10, 1'b0, 1'b0);
      begin
        repeat (2000) @(negedge clk);
        baud_rate = 2'b00;
        parity_type = 2'b00;
      end
    join
    chk("t6_data",  rx.rx_data, 8'h81);
    chk("t6_perr",  rx.rx_perr, 0);
    chk("t6_ferr",  rx.rx_ferr, 0);
    chk("t6_level", fifo_level, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
